// File: rtl/e_mdu_issue_pkg.sv
// Shared HILO op codes, issue FSM states and op-class helpers for the E-stage MDU issuer.
// Optional build macro used by the top: MDU_WATCHDOG_EN.
package e_mdu_issue_pkg;

   typedef enum logic [3:0] {
      HILO_NONE  = 4'd0,
      HILO_MULT  = 4'd1,
      HILO_MULTU = 4'd2,
      HILO_DIV   = 4'd3,
      HILO_DIVU  = 4'd4,
      HILO_MFHI  = 4'd5,
      HILO_MFLO  = 4'd6,
      HILO_MTHI  = 4'd7,
      HILO_MTLO  = 4'd8
   } hilo_op_e;

   typedef enum logic [1:0] {
      MDI_IDLE  = 2'd0,
      MDI_ISSUE = 2'd1,
      MDI_WAIT  = 2'd2
   } mdi_state_e;

   function automatic logic is_md(input logic [3:0] op);
      return (op == HILO_MULT) || (op == HILO_MULTU) || (op == HILO_DIV) || (op == HILO_DIVU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == HILO_DIV) || (op == HILO_DIVU);
   endfunction

   function automatic logic is_mf(input logic [3:0] op);
      return (op == HILO_MFHI) || (op == HILO_MFLO);
   endfunction

   function automatic logic is_mt(input logic [3:0] op);
      return (op == HILO_MTHI) || (op == HILO_MTLO);
   endfunction

endpackage

// File: rtl/e_mdu_issue_if.sv
// MDU command bus: the issuer (master) drives op/operands, the MDU (slave) returns busy/read data.
interface e_mdu_issue_if;
   logic [3:0]  md_op;
   logic [31:0] md_rs;
   logic [31:0] md_rt;
   logic        md_busy;
   logic [31:0] md_result;

   modport master (output md_op, output md_rs, output md_rt, input md_busy, input md_result);
   modport slave  (input md_op, input md_rs, input md_rt, output md_busy, output md_result);
endinterface

// File: rtl/e_mdu_issue.sv
// E-stage issuer for the HI/LO multiply-divide unit: launches mult/div, tracks md_busy, stalls D.
// Build macro MDU_WATCHDOG_EN adds a busy-timeout counter and the sticky wd_err flag.
module e_mdu_issue
   import e_mdu_issue_pkg::*;
`ifdef MDU_WATCHDOG_EN
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int WD_SLACK    = 4
)
`endif
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Req,
   input  logic [3:0]           D_opHILO,
   input  logic [3:0]           E_opHILO,
   input  logic [31:0]          E_rs,
   input  logic [31:0]          E_rt,
   e_mdu_issue_if.master        md,
   output logic                 stall_D,
   output logic [31:0]          E_mdresult,
   output logic                 wd_err
);

   mdi_state_e  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;

`ifdef MDU_WATCHDOG_EN
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES + WD_SLACK);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES + WD_SLACK);
   logic [3:0] cnt_q, cnt_d;
   logic       wd_err_q, wd_err_d;
`endif

   // Next-state and operand-latch computation for the issue FSM.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
`ifdef MDU_WATCHDOG_EN
      cnt_d    = cnt_q;
      wd_err_d = wd_err_q;
`endif
      case (state_q)
         MDI_IDLE: begin
            if (is_md(E_opHILO) && !Req) begin
               op_d    = E_opHILO;
               rs_d    = E_rs;
               rt_d    = E_rt;
               state_d = MDI_ISSUE;
            end else begin
               state_d = MDI_IDLE;
            end
         end
         MDI_ISSUE: begin
            state_d = Req ? MDI_IDLE : MDI_WAIT;
`ifdef MDU_WATCHDOG_EN
            cnt_d = is_div(op_q) ? DIV_LOAD : MULT_LOAD;
`endif
         end
         MDI_WAIT: begin
            // The MDU is frozen while Req is high, so the wait (and its timeout) pauses too.
            if (Req) begin
               state_d = MDI_WAIT;
`ifdef MDU_WATCHDOG_EN
            end else if (md.md_busy && (cnt_q <= 4'd1)) begin
               wd_err_d = 1'b1;
               cnt_d    = 4'd0;
               state_d  = MDI_IDLE;
            end else if (md.md_busy) begin
               cnt_d   = cnt_q - 4'd1;
               state_d = MDI_WAIT;
`endif
            end else if (!md.md_busy) begin
               state_d = MDI_IDLE;
            end else begin
               state_d = MDI_WAIT;
            end
         end
         default: state_d = MDI_IDLE;
      endcase
   end

   // State and operand registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MDI_IDLE;
         op_q    <= HILO_NONE;
         rs_q    <= 32'd0;
         rt_q    <= 32'd0;
`ifdef MDU_WATCHDOG_EN
         cnt_q    <= 4'd0;
         wd_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
`ifdef MDU_WATCHDOG_EN
         cnt_q    <= cnt_d;
         wd_err_q <= wd_err_d;
`endif
      end
   end

   // MDU command bus and mfhi/mflo read path; mt/mf go straight through while idle.
   always_comb begin
      md.md_op   = HILO_NONE;
      md.md_rs   = 32'd0;
      md.md_rt   = 32'd0;
      E_mdresult = 32'd0;
      case (state_q)
         MDI_IDLE: begin
            if (is_mt(E_opHILO)) begin
               md.md_op = E_opHILO;
               md.md_rs = E_rs;
            end else if (is_mf(E_opHILO)) begin
               md.md_op   = E_opHILO;
               E_mdresult = md.md_result;
            end else begin
               md.md_op = HILO_NONE;
            end
         end
         MDI_ISSUE: begin
            if (!Req) begin
               md.md_op = op_q;
               md.md_rs = rs_q;
               md.md_rt = rt_q;
            end else begin
               md.md_op = HILO_NONE;
            end
         end
         default: md.md_op = HILO_NONE;
      endcase
   end

   assign stall_D = (D_opHILO != HILO_NONE) && ((state_q != MDI_IDLE) || is_md(E_opHILO));

`ifdef MDU_WATCHDOG_EN
   assign wd_err = wd_err_q;
`else
   assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_e_mdu_issue.sv
// Self-checking bench for e_mdu_issue: directed scenarios then randomized mult/div/mt/mf traffic
// against a transaction-level model; the MDU_WATCHDOG_EN scenario runs only when that macro is set.
module tb_e_mdu_issue;
   import e_mdu_issue_pkg::*;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;
   localparam int WD_SLACK    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Req = 1'b0;
   logic [3:0]  D_opHILO = 4'd0;
   logic [3:0]  E_opHILO = 4'd0;
   logic [31:0] E_rs = 32'd0;
   logic [31:0] E_rt = 32'd0;
   logic        stall_D;
   logic [31:0] E_mdresult;
   logic        wd_err;

   int checks = 0;
   int fails  = 0;

   e_mdu_issue_if mdif();

   always #5 clk = ~clk;

   e_mdu_issue dut (
      .clk(clk), .reset(reset), .Req(Req), .D_opHILO(D_opHILO), .E_opHILO(E_opHILO),
      .E_rs(E_rs), .E_rt(E_rt), .md(mdif), .stall_D(stall_D), .E_mdresult(E_mdresult),
      .wd_err(wd_err)
   );

   function automatic logic b_is_md(input logic [3:0] op);
      return op inside {HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU};
   endfunction
   function automatic logic b_is_mt(input logic [3:0] op);
      return op inside {HILO_MTHI, HILO_MTLO};
   endfunction
   function automatic logic b_is_mf(input logic [3:0] op);
      return op inside {HILO_MFHI, HILO_MFLO};
   endfunction

   // {hi, lo} produced by a completed mult/div
   function automatic logic [63:0] arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int    sa, sb;
      longint p;
      sa = a;
      sb = b;
      case (op)
         HILO_MULT:  begin p = longint'(sa) * longint'(sb); return p; end
         HILO_MULTU: return {32'd0, a} * {32'd0, b};
         HILO_DIV:   return {32'(sa % sb), 32'(sa / sb)};
         HILO_DIVU:  return {a % b, a / b};
         default:    return 64'd0;
      endcase
   endfunction

   // Behavioural MDU: starts on a mult/div command, stays busy a fixed time, freezes during Req.
   logic [31:0] mdu_hi, mdu_lo;
   int          mdu_cnt;
   logic        force_busy = 1'b0;
   always_ff @(posedge clk) begin
      if (reset) begin
         mdu_cnt <= 0;
         mdu_hi  <= 32'd0;
         mdu_lo  <= 32'd0;
      end else if (b_is_md(mdif.md_op)) begin
         {mdu_hi, mdu_lo} <= arith(mdif.md_op, mdif.md_rs, mdif.md_rt);
         mdu_cnt <= (mdif.md_op inside {HILO_DIV, HILO_DIVU}) ? DIV_CYCLES : MULT_CYCLES;
      end else begin
         if (mdif.md_op == HILO_MTHI) mdu_hi <= mdif.md_rs;
         if (mdif.md_op == HILO_MTLO) mdu_lo <= mdif.md_rs;
         if (mdu_cnt > 0 && !Req) mdu_cnt <= mdu_cnt - 1;
      end
   end
   assign mdif.md_busy   = (mdu_cnt != 0) || force_busy;
   assign mdif.md_result = (mdif.md_op == HILO_MFHI) ? mdu_hi :
                           (mdif.md_op == HILO_MFLO) ? mdu_lo : 32'd0;

   // Reference model: an op is either captured-but-not-sent, in flight, or nothing is outstanding.
   logic        m_pend = 1'b0, m_infl = 1'b0, m_wd = 1'b0;
   logic [3:0]  m_op = 4'd0;
   logic [31:0] m_rs = 32'd0, m_rt = 32'd0, ref_hi = 32'd0, ref_lo = 32'd0;
   int          m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      D_opHILO = HILO_NONE; E_opHILO = HILO_NONE; Req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_pend = 1'b0; m_infl = 1'b0; m_wd = 1'b0;
      ref_hi = 32'd0; ref_lo = 32'd0;
   endtask

   // One clock: drive inputs, check outputs mid-cycle, then advance the model.
   task automatic cyc(input logic [3:0] dop, input logic [3:0] eop, input logic [31:0] rs,
                      input logic [31:0] rt, input logic req);
      logic        idle, busy_s;
      logic [3:0]  e_op;
      logic [31:0] e_rs, e_rt, e_res;
      D_opHILO = dop; E_opHILO = eop; E_rs = rs; E_rt = rt; Req = req;
      @(negedge clk);
      idle = !m_pend && !m_infl;
      if (idle) e_op = (b_is_mt(eop) || b_is_mf(eop)) ? eop : HILO_NONE;
      else if (m_pend && !req) e_op = m_op;
      else e_op = HILO_NONE;
      e_rs  = b_is_mt(e_op) ? rs : (b_is_md(e_op) ? m_rs : 32'd0);
      e_rt  = b_is_md(e_op) ? m_rt : 32'd0;
      e_res = (idle && eop == HILO_MFHI) ? ref_hi : ((idle && eop == HILO_MFLO) ? ref_lo : 32'd0);
      chk("md_op", {28'd0, mdif.md_op}, {28'd0, e_op});
      chk("md_rs", mdif.md_rs, e_rs);
      chk("md_rt", mdif.md_rt, e_rt);
      chk("stall_D", {31'd0, stall_D}, {31'd0, (dop != HILO_NONE) && (!idle || b_is_md(eop))});
      chk("E_mdresult", E_mdresult, e_res);
      chk("wd_err", {31'd0, wd_err}, {31'd0, m_wd});
      busy_s = mdif.md_busy;
      @(posedge clk); #1;
      if (idle) begin
         if (b_is_md(eop) && !req) begin
            m_pend = 1'b1; m_op = eop; m_rs = rs; m_rt = rt;
         end
         if (eop == HILO_MTHI) ref_hi = rs;
         if (eop == HILO_MTLO) ref_lo = rs;
      end else if (m_pend) begin
         m_pend = 1'b0;
         if (!req) begin
            m_infl = 1'b1;
            {ref_hi, ref_lo} = arith(m_op, m_rs, m_rt);
            m_cnt = (m_op inside {HILO_DIV, HILO_DIVU}) ? DIV_CYCLES + WD_SLACK : MULT_CYCLES + WD_SLACK;
         end
      end else if (!req) begin
         if (!busy_s) m_infl = 1'b0;
`ifdef MDU_WATCHDOG_EN
         else if (m_cnt <= 1) begin m_wd = 1'b1; m_infl = 1'b0; end
         else m_cnt = m_cnt - 1;
`endif
      end
   endtask

   // Run until nothing is outstanding; an expired bound is a failed check.
   task automatic wait_done(input logic [3:0] dop, input logic rand_mode);
      for (int i = 0; i < 60 && (m_pend || m_infl); i++) begin
         if (rand_mode)
            cyc($urandom_range(0, 1) ? HILO_MFHI : HILO_NONE, HILO_NONE, 32'd0, 32'd0,
                ($urandom_range(0, 7) == 0));
         else
            cyc(dop, HILO_NONE, 32'd0, 32'd0, 1'b0);
      end
      checks++;
      if (m_pend || m_infl) begin
         fails++;
         $error("FAIL wait_timeout: observed busy expected idle within 60 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      do_reset();
      cyc(HILO_NONE, HILO_NONE, 32'd0, 32'd0, 1'b0);

      // 1: mult 7 * -3, then mflo
      cyc(HILO_NONE, HILO_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
      wait_done(HILO_NONE, 1'b0);
      cyc(HILO_NONE, HILO_MFLO, 32'd0, 32'd0, 1'b0);
      cyc(HILO_NONE, HILO_MFHI, 32'd0, 32'd0, 1'b0);

      // 2: div 100/7 with mfhi waiting in D
      cyc(HILO_MFHI, HILO_DIV, 32'd100, 32'd7, 1'b0);
      wait_done(HILO_MFHI, 1'b0);
      cyc(HILO_MFHI, HILO_NONE, 32'd0, 32'd0, 1'b0);
      cyc(HILO_NONE, HILO_MFHI, 32'd0, 32'd0, 1'b0);

      // 3: mult cancelled by Req in ISSUE
      cyc(HILO_NONE, HILO_MULT, 32'd5, 32'd6, 1'b0);
      cyc(HILO_MFLO, HILO_NONE, 32'd0, 32'd0, 1'b1);
      cyc(HILO_MFLO, HILO_NONE, 32'd0, 32'd0, 1'b0);
      cyc(HILO_NONE, HILO_MFLO, 32'd0, 32'd0, 1'b0);

      // Req in IDLE drops the op
      cyc(HILO_MFHI, HILO_DIVU, 32'd9, 32'd2, 1'b1);
      cyc(HILO_MFHI, HILO_NONE, 32'd0, 32'd0, 1'b0);

      // 4: mthi then mfhi
      cyc(HILO_NONE, HILO_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
      cyc(HILO_NONE, HILO_MFHI, 32'd0, 32'd0, 1'b0);

      // 5: reset mid-WAIT of divu, then md_busy high in IDLE is ignored
      cyc(HILO_NONE, HILO_DIVU, 32'd1000, 32'd3, 1'b0);
      for (int i = 0; i < 4; i++) cyc(HILO_MFLO, HILO_NONE, 32'd0, 32'd0, 1'b0);
      do_reset();
      cyc(HILO_MFLO, HILO_NONE, 32'd0, 32'd0, 1'b0);
      force_busy = 1'b1;
      cyc(HILO_MFHI, HILO_NONE, 32'd0, 32'd0, 1'b0);
      cyc(HILO_MFHI, HILO_MTLO, 32'h1234_5678, 32'd0, 1'b0);
      force_busy = 1'b0;
      cyc(HILO_NONE, HILO_MFLO, 32'd0, 32'd0, 1'b0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = $urandom;
         if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
         if ($urandom_range(0, 9) < 2) begin
            cyc($urandom_range(0, 1) ? HILO_MFLO : HILO_NONE,
                $urandom_range(0, 1) ? HILO_MTHI : HILO_MTLO, a, b, 1'b0);
         end else begin
            op = 4'($urandom_range(1, 4));
            cyc($urandom_range(0, 1) ? HILO_MFHI : HILO_NONE, op, a, b, ($urandom_range(0, 7) == 0));
            wait_done(HILO_NONE, 1'b1);
         end
         cyc($urandom_range(0, 1) ? HILO_MULT : HILO_NONE, HILO_MFHI, 32'd0, 32'd0, 1'b0);
         cyc(HILO_NONE, HILO_MFLO, 32'd0, 32'd0, 1'b0);
      end

`ifdef MDU_WATCHDOG_EN
      // 6: MDU stuck busy after a mult
      cyc(HILO_NONE, HILO_MULT, 32'd3, 32'd4, 1'b0);
      force_busy = 1'b1;
      wait_done(HILO_NONE, 1'b0);
      cyc(HILO_MFHI, HILO_NONE, 32'd0, 32'd0, 1'b0);
      force_busy = 1'b0;
      cyc(HILO_NONE, HILO_NONE, 32'd0, 32'd0, 1'b0);
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
